fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit; successor to the 2-source, 2-stage forwarding control.
- Sits beside the ID stage. Selects bypass sources for NUM_SRC operands across NUM_FWD_STAGES downstream stages.
- Generates load-use and not-ready stalls.
- Keeps a registered scoreboard of outstanding multi-cycle writes (MUL/DIV), up to MC_DEPTH in flight, with RAW, WAW and capacity stalls.

---
 rtl/fwd_hazard_unit.sv | 113 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand bypass selection, load-use/not-ready stalls and a multi-cycle write scoreboard.
// Optional stall performance counter is compiled in with HAZ_PERF_EN.
module fwd_hazard_unit #(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int MC_DEPTH       = 2,
  localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_FWD_STAGES-1:0]          stg_wen,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] stg_rd,
  input  logic [NUM_FWD_STAGES-1:0]          stg_rdy,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]      src_rs,
  input  logic [NUM_SRC-1:0]                 src_used,
  input  logic                               mc_req,
  input  logic [REG_ADDR_W-1:0]              mc_rd,
  input  logic                               mc_wb,
  input  logic [REG_ADDR_W-1:0]              mc_wb_rd,
  output logic [NUM_SRC*SEL_W-1:0]           fw_sel,
  output logic [NUM_SRC-1:0]                 fw_hit,
  output logic                               stall,
  output logic                               mc_issue,
  output logic [2:0]                         mc_cnt,
  output logic [31:0]                        perf_stall_cnt
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [NUM_REGS-1:0] busy_reg;
  logic [2:0]          cnt_reg;
  logic [NUM_SRC-1:0]  src_haz;
  logic                waw_haz;
  logic                cap_haz;
  logic                wb_eff;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] rs;
      logic                  found;
      logic                  found_rdy;
      logic [SEL_W-1:0]      sel;

      assign rs = src_rs[gi*REG_ADDR_W +: REG_ADDR_W];

      // Scan oldest to youngest so the youngest matching stage is the one kept.
      always_comb begin
        found     = 1'b0;
        found_rdy = 1'b0;
        sel       = '0;
        if (src_used[gi] && (rs != '0)) begin
          for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (stg_wen[k] && (stg_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
              found     = 1'b1;
              found_rdy = stg_rdy[k];
              sel       = SEL_W'(k + 1);
            end
          end
        end
      end

      // A not-ready youngest match blocks; older stages hold stale values.
      assign fw_sel[gi*SEL_W +: SEL_W] = (found && found_rdy) ? sel : '0;
      assign fw_hit[gi] = found && found_rdy;
      assign src_haz[gi] = src_used[gi] && (rs != '0) &&
                           (found ? !found_rdy : busy_reg[rs]);
    end
  endgenerate

  assign waw_haz  = mc_req && (mc_rd != '0) && busy_reg[mc_rd];
  assign cap_haz  = mc_req && (cnt_reg == 3'(MC_DEPTH));
  assign stall    = (|src_haz) || waw_haz || cap_haz;
  assign mc_issue = mc_req && !stall;
  assign mc_cnt   = cnt_reg;

  // Writebacks with nothing outstanding are spurious and dropped entirely.
  assign wb_eff = mc_wb && (cnt_reg != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      cnt_reg  <= 3'd0;
    end else begin
      if (wb_eff && (mc_wb_rd != '0))
        busy_reg[mc_wb_rd] <= 1'b0;
      if (mc_issue && (mc_rd != '0))
        busy_reg[mc_rd] <= 1'b1;
      case ({mc_issue, wb_eff})
        2'b10:   cnt_reg <= cnt_reg + 3'd1;
        2'b01:   cnt_reg <= cnt_reg - 3'd1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_reg <= '0;
    else if (stall && (perf_reg != 32'hFFFF_FFFF))
      perf_reg <= perf_reg + 32'd1;
  end

  assign perf_stall_cnt = perf_reg;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then random traffic against a queue-based model.
// Expects perf_stall_cnt to track stall cycles when HAZ_PERF_EN is defined, else zero.
module tb_fwd_hazard_unit;
  localparam int NS = 2;
  localparam int NF = 2;
  localparam int W  = 5;
  localparam int MD = 2;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NF-1:0]   stg_wen;
  logic [NF*W-1:0] stg_rd;
  logic [NF-1:0]   stg_rdy;
  logic [NS*W-1:0] src_rs;
  logic [NS-1:0]   src_used;
  logic            mc_req;
  logic [W-1:0]    mc_rd;
  logic            mc_wb;
  logic [W-1:0]    mc_wb_rd;
  logic [NS*SW-1:0] fw_sel;
  logic [NS-1:0]   fw_hit;
  logic            stall;
  logic            mc_issue;
  logic [2:0]      mc_cnt;
  logic [31:0]     perf_stall_cnt;

  int checks = 0;
  int errors = 0;
  int outstanding[$];
  int stall_cycles = 0;

  fwd_hazard_unit #(.NUM_SRC(NS), .NUM_FWD_STAGES(NF), .REG_ADDR_W(W), .MC_DEPTH(MD)) dut (
    .clk(clk), .rst_n(rst_n), .stg_wen(stg_wen), .stg_rd(stg_rd), .stg_rdy(stg_rdy),
    .src_rs(src_rs), .src_used(src_used), .mc_req(mc_req), .mc_rd(mc_rd),
    .mc_wb(mc_wb), .mc_wb_rd(mc_wb_rd), .fw_sel(fw_sel), .fw_hit(fw_hit),
    .stall(stall), .mc_issue(mc_issue), .mc_cnt(mc_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_outstanding(input int r);
    foreach (outstanding[i]) if (outstanding[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    stg_wen = '0; stg_rd = '0; stg_rdy = '0; src_rs = '0; src_used = '0;
    mc_req = 1'b0; mc_rd = '0; mc_wb = 1'b0; mc_wb_rd = '0;
  endtask

  // Compare all outputs against the model, then clock once and advance the model.
  task automatic step(input string tag);
    logic [NS*SW-1:0] e_sel;
    logic [NS-1:0]    e_hit;
    bit               e_stall;
    bit               e_issue;
    logic [31:0]      e_perf;
    int               rs;
    int               hit_k;
    e_sel = '0; e_hit = '0; e_stall = 1'b0;
    for (int j = 0; j < NS; j++) begin
      rs = int'(src_rs[j*W +: W]);
      if (src_used[j] && rs != 0) begin
        hit_k = -1;
        for (int k = 0; k < NF; k++) begin
          if (stg_wen[k] && int'(stg_rd[k*W +: W]) == rs) begin
            hit_k = k;
            break;
          end
        end
        if (hit_k >= 0) begin
          if (stg_rdy[hit_k]) begin
            e_sel[j*SW +: SW] = 2'(hit_k + 1);
            e_hit[j] = 1'b1;
          end else e_stall = 1'b1;
        end else if (is_outstanding(rs)) e_stall = 1'b1;
      end
    end
    if (mc_req && ((mc_rd != 0 && is_outstanding(int'(mc_rd))) || outstanding.size() == MD))
      e_stall = 1'b1;
    e_issue = mc_req && !e_stall;
`ifdef HAZ_PERF_EN
    e_perf = 32'(stall_cycles);
`else
    e_perf = 32'd0;
`endif
    check({tag, ".fw_sel"},  32'(fw_sel),   32'(e_sel));
    check({tag, ".fw_hit"},  32'(fw_hit),   32'(e_hit));
    check({tag, ".stall"},   32'(stall),    32'(e_stall));
    check({tag, ".issue"},   32'(mc_issue), 32'(e_issue));
    check({tag, ".mc_cnt"},  32'(mc_cnt),   32'(outstanding.size()));
    check({tag, ".perf"},    perf_stall_cnt, e_perf);
    $display("txn %s rs=%h used=%b req=%b rd=%0d wb=%b wbrd=%0d stall=%b issue=%b cnt=%0d",
             tag, src_rs, src_used, mc_req, mc_rd, mc_wb, mc_wb_rd, stall, mc_issue, mc_cnt);
    @(posedge clk);
    if (e_stall) stall_cycles++;
    if (mc_wb && outstanding.size() > 0) begin
      foreach (outstanding[i]) if (outstanding[i] == int'(mc_wb_rd)) begin
        outstanding.delete(i);
        break;
      end
    end
    if (e_issue) outstanding.push_back(int'(mc_rd));
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("reset.fw_sel", 32'(fw_sel), 32'd0);
    check("reset.stall",  32'(stall),  32'd0);
    check("reset.cnt",    32'(mc_cnt), 32'd0);
    check("reset.perf",   perf_stall_cnt, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Not-ready youngest stage blocks even though an older stage is ready; three cycles.
    for (int i = 0; i < 3; i++) begin
      idle();
      stg_wen = 2'b11; stg_rd = {5'd7, 5'd7}; stg_rdy = 2'b10;
      src_rs[1*W +: W] = 5'd7; src_used = 2'b10;
      #1;
      check("loaduse.stall", 32'(stall), 32'd1);
      check("loaduse.sel1",  32'(fw_sel[SW +: SW]), 32'd0);
      step("loaduse");
    end
`ifdef HAZ_PERF_EN
    check("perf.three", perf_stall_cnt, 32'd3);
`else
    check("perf.three", perf_stall_cnt, 32'd0);
`endif

    idle();
    stg_wen = 2'b11; stg_rd = {5'd5, 5'd5}; stg_rdy = 2'b11;
    src_rs[0 +: W] = 5'd5; src_used = 2'b01;
    #1;
    check("youngest.sel0", 32'(fw_sel[0 +: SW]), 32'd1);
    check("youngest.hit0", 32'(fw_hit[0]), 32'd1);
    step("youngest");

    idle();
    stg_wen = 2'b01; stg_rd = '0;
    src_rs = {5'd3, 5'd0}; src_used = 2'b01;
    #1;
    check("x0unused.sel",   32'(fw_sel), 32'd0);
    check("x0unused.stall", 32'(stall),  32'd0);
    step("x0unused");

    idle(); mc_req = 1'b1; mc_rd = 5'd9;
    #1; check("mc9.issue", 32'(mc_issue), 32'd1);
    step("mc9");
    check("mc9.cnt", 32'(mc_cnt), 32'd1);
    for (int i = 0; i < 2; i++) begin
      idle(); src_rs[0 +: W] = 5'd9; src_used = 2'b01;
      #1; check("raw9.stall", 32'(stall), 32'd1);
      step("raw9");
    end
    mc_wb = 1'b1; mc_wb_rd = 5'd9;
    #1; check("raw9wb.stall", 32'(stall), 32'd1);
    step("raw9wb");
    mc_wb = 1'b0;
    #1;
    check("raw9clr.stall", 32'(stall),  32'd0);
    check("raw9clr.cnt",   32'(mc_cnt), 32'd0);
    step("raw9clr");

    idle(); mc_req = 1'b1; mc_rd = 5'd4; #1; step("cap4");
    mc_rd = 5'd6; #1; step("cap6");
    mc_rd = 5'd8; mc_wb = 1'b1; mc_wb_rd = 5'd4;
    #1;
    check("cap8.stall", 32'(stall),    32'd1);
    check("cap8.issue", 32'(mc_issue), 32'd0);
    step("cap8full");
    mc_wb = 1'b0;
    #1; check("cap8.retry", 32'(mc_issue), 32'd1);
    step("cap8retry");
    idle(); #1; check("cap8.cnt", 32'(mc_cnt), 32'd2);
    mc_wb = 1'b1; mc_wb_rd = 5'd6; #1; step("drain6");
    mc_wb_rd = 5'd8; #1; step("drain8");
    mc_wb_rd = 5'd3; #1; step("wbempty");

    // Asynchronous reset while a RAW stall is active.
    idle(); mc_req = 1'b1; mc_rd = 5'd9; #1; step("rst.issue");
    idle(); src_rs[0 +: W] = 5'd9; src_used = 2'b01; #1; step("rst.stall");
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid.cnt",   32'(mc_cnt), 32'd0);
    check("rstmid.stall", 32'(stall),  32'd0);
    check("rstmid.perf",  perf_stall_cnt, 32'd0);
    outstanding.delete();
    stall_cycles = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 400; n++) begin
      stg_wen = 2'($urandom);
      stg_rdy = 2'($urandom);
      for (int k = 0; k < NF; k++) stg_rd[k*W +: W] = 5'($urandom_range(0, 7));
      for (int j = 0; j < NS; j++) src_rs[j*W +: W] = 5'($urandom_range(0, 7));
      src_used = 2'($urandom);
      mc_req = ($urandom_range(0, 2) == 0);
      mc_rd = 5'($urandom_range(0, 7));
      mc_wb = 1'b0; mc_wb_rd = '0;
      if (outstanding.size() > 0 && $urandom_range(0, 3) == 0) begin
        mc_wb = 1'b1;
        mc_wb_rd = 5'(outstanding[$urandom_range(0, outstanding.size() - 1)]);
      end else if (outstanding.size() == 0 && $urandom_range(0, 7) == 0) begin
        mc_wb = 1'b1;
        mc_wb_rd = 5'($urandom_range(0, 7));
      end
      #1;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
